cam_lot_aged: RTL and testbench

Parametrised successor to the basic tag CAM lot. Stores up to DEPTH tags of TAG_WIDTH bits and serves PARK, RETRIEVE, PEEK and FLUSH requests over valid/ready handshakes, one request at a time. Each stored entry carries a saturating age counter advanced by an external tick; entries expire at MAX_AGE. Sits between the valet request arbiter and the response/ticketing logic.

---
 rtl/cam_lot_aged.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_cam_lot_aged.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lot_aged.sv
// Tag CAM lot with per-entry saturating age counters and expiry on an external tick.
// Optional limbo FIFO of expired tags (GHOST responses) enabled by defining CAM_LIMBO_EN.
module cam_lot_aged #(
  parameter int TAG_WIDTH   = 16,
  parameter int DEPTH       = 8,
  parameter int AGE_WIDTH   = 4,
  parameter int MAX_AGE     = 12,
  parameter int LIMBO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  input  logic                     age_tick,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_status,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic [$clog2(DEPTH)-1:0] rsp_index,
  output logic [AGE_WIDTH-1:0]     rsp_age,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              expired_cnt
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AGE_WIDTH-1:0] AMAX = AGE_WIDTH'(MAX_AGE);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;
  typedef enum logic [1:0] {OP_PARK = 2'd0, OP_RETRIEVE = 2'd1, OP_PEEK = 2'd2, OP_FLUSH = 2'd3} op_t;
  typedef enum logic [2:0] {ST_OK = 3'd0, ST_FULL = 3'd1, ST_DUP = 3'd2, ST_MISS = 3'd3, ST_GHOST = 3'd4} status_t;

  state_t                 r_state, w_state_nx;
  op_t                    r_op;
  logic [TAG_WIDTH-1:0]   r_req_tag;
  logic [DEPTH-1:0]       r_valid, w_valid_nx, w_exp;
  logic [AGE_WIDTH-1:0]   r_age    [DEPTH];
  logic [AGE_WIDTH-1:0]   w_age_nx [DEPTH];
  logic [TAG_WIDTH-1:0]   r_tag    [DEPTH];
  logic                   w_match, w_free, w_wr_en, w_search;
  logic [IW-1:0]          w_midx, w_fidx;
  status_t                w_st;
  logic [TAG_WIDTH-1:0]   w_rtag;
  logic [IW-1:0]          w_ridx;
  logic [AGE_WIDTH-1:0]   w_rage;
  logic [IW:0]            w_occ_nx, w_exp_n;
  logic [16:0]            w_exp_sum;
  logic [2:0]             r_rsp_status;
  logic [TAG_WIDTH-1:0]   r_rsp_tag;
  logic [IW-1:0]          r_rsp_index;
  logic [AGE_WIDTH-1:0]   r_rsp_age;
  logic [IW:0]            r_occ;
  logic [15:0]            r_expired;

  assign w_search    = (r_state == S_SEARCH);
  assign rsp_status  = r_rsp_status;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_index   = r_rsp_index;
  assign rsp_age     = r_rsp_age;
  assign occupancy   = r_occ;
  assign expired_cnt = r_expired;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nx = S_SEARCH;
      end
      S_SEARCH: w_state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Lowest matching and lowest free slot, both from pre-tick state.
  always_comb begin
    w_match = 1'b0;
    w_midx  = '0;
    w_free  = 1'b0;
    w_fidx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_match && r_valid[i] && (r_tag[i] == r_req_tag)) begin
        w_match = 1'b1;
        w_midx  = IW'(i);
      end
      if (!w_free && !r_valid[i]) begin
        w_free = 1'b1;
        w_fidx = IW'(i);
      end
    end
  end

`ifdef CAM_LIMBO_EN
  localparam int LW = (LIMBO_DEPTH > 1) ? $clog2(LIMBO_DEPTH) : 1;
  logic [LIMBO_DEPTH-1:0] r_lv, w_lv_nx;
  logic [TAG_WIDTH-1:0]   r_lt    [LIMBO_DEPTH];
  logic [TAG_WIDTH-1:0]   w_lt_nx [LIMBO_DEPTH];
  logic [LW-1:0]          r_lptr, w_lptr_nx;
  logic                   w_lhit;
  logic [LW-1:0]          w_lidx;

  always_comb begin
    w_lhit = 1'b0;
    w_lidx = '0;
    for (int unsigned i = 0; i < LIMBO_DEPTH; i++) begin
      if (!w_lhit && r_lv[i] && (r_lt[i] == r_req_tag)) begin
        w_lhit = 1'b1;
        w_lidx = LW'(i);
      end
    end
  end

  // Removals are applied before this edge's expiry pushes; pushes overwrite the oldest slot.
  always_comb begin
    w_lv_nx   = r_lv;
    w_lt_nx   = r_lt;
    w_lptr_nx = r_lptr;
    if (w_search && !w_match && w_lhit &&
        ((r_op == OP_RETRIEVE) || ((r_op == OP_PARK) && w_free)))
      w_lv_nx[w_lidx] = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_exp[i]) begin
        w_lv_nx[w_lptr_nx] = 1'b1;
        w_lt_nx[w_lptr_nx] = r_tag[i];
        w_lptr_nx = (w_lptr_nx == LW'(LIMBO_DEPTH - 1)) ? '0 : w_lptr_nx + 1'b1;
      end
    end
    if (w_search && (r_op == OP_FLUSH)) begin
      w_lv_nx   = '0;
      w_lptr_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lv   <= '0;
      r_lptr <= '0;
    end else begin
      r_lv   <= w_lv_nx;
      r_lptr <= w_lptr_nx;
    end
  end

  always_ff @(posedge clk) r_lt <= w_lt_nx;
`endif

  // Aging first, then the SEARCH commit overrides it for the touched slots.
  always_comb begin
    w_valid_nx = r_valid;
    w_age_nx   = r_age;
    w_exp      = '0;
    w_wr_en    = 1'b0;
    if (age_tick) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          w_age_nx[i] = (r_age[i] == AMAX) ? AMAX : r_age[i] + 1'b1;
          if (w_age_nx[i] == AMAX) begin
            w_valid_nx[i] = 1'b0;
            w_exp[i]      = 1'b1;
          end
        end
      end
    end
    if (w_search) begin
      case (r_op)
        OP_PARK: begin
          if (!w_match && w_free) begin
            w_valid_nx[w_fidx] = 1'b1;
            w_age_nx[w_fidx]   = '0;
            w_wr_en            = 1'b1;
          end
        end
        OP_RETRIEVE: begin
          if (w_match) begin
            w_valid_nx[w_midx] = 1'b0;
            w_exp[w_midx]      = 1'b0;
          end
        end
        OP_FLUSH: begin
          w_valid_nx = '0;
          w_exp      = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_st   = ST_OK;
    w_rtag = r_req_tag;
    w_ridx = '0;
    w_rage = '0;
    case (r_op)
      OP_PARK: begin
        if (w_match) begin
          w_st   = ST_DUP;
          w_ridx = w_midx;
          w_rage = r_age[w_midx];
        end else if (!w_free) begin
          w_st = ST_FULL;
        end else begin
          w_ridx = w_fidx;
        end
      end
      OP_RETRIEVE, OP_PEEK: begin
        if (w_match) begin
          w_rtag = r_tag[w_midx];
          w_ridx = w_midx;
          w_rage = r_age[w_midx];
        end
`ifdef CAM_LIMBO_EN
        else if (w_lhit) begin
          w_st   = ST_GHOST;
          w_rtag = r_lt[w_lidx];
          w_ridx = IW'(w_lidx);
          w_rage = AMAX;
        end
`endif
        else begin
          w_st = ST_MISS;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_occ_nx = '0;
    w_exp_n  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ_nx = w_occ_nx + {{IW{1'b0}}, w_valid_nx[i]};
      w_exp_n  = w_exp_n + {{IW{1'b0}}, w_exp[i]};
    end
    w_exp_sum = {1'b0, r_expired} + 17'(w_exp_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= '0;
      r_occ        <= '0;
      r_expired    <= '0;
      r_op         <= OP_PARK;
      r_req_tag    <= '0;
      r_rsp_status <= '0;
      r_rsp_tag    <= '0;
      r_rsp_index  <= '0;
      r_rsp_age    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      r_valid   <= w_valid_nx;
      r_age     <= w_age_nx;
      r_occ     <= w_occ_nx;
      r_expired <= w_exp_sum[16] ? 16'hFFFF : w_exp_sum[15:0];
      if (req_valid && req_ready) begin
        r_op      <= op_t'(req_op);
        r_req_tag <= req_tag;
      end
      if (w_search) begin
        r_rsp_status <= w_st;
        r_rsp_tag    <= w_rtag;
        r_rsp_index  <= w_ridx;
        r_rsp_age    <= w_rage;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_tag[w_fidx] <= r_req_tag;
  end

endmodule

// File: tb/tb_cam_lot_aged.sv
// Scoreboard bench for cam_lot_aged: directed scenarios plus randomized traffic
// checked against a slot-array reference model of the CAM rules.
module tb_cam_lot_aged;
  localparam int TW   = 16;
  localparam int D    = 8;
  localparam int AW   = 4;
  localparam int MAXA = 12;
`ifdef CAM_LIMBO_EN
  localparam int TICK_PCT = 0;
`else
  localparam int TICK_PCT = 30;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [TW-1:0] req_tag = '0;
  logic          age_tick = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [2:0]    rsp_status;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    rsp_index;
  logic [AW-1:0] rsp_age;
  logic [3:0]    occupancy;
  logic [15:0]   expired_cnt;

  always #5 clk = ~clk;

  cam_lot_aged #(.TAG_WIDTH(TW), .DEPTH(D), .AGE_WIDTH(AW), .MAX_AGE(MAXA), .LIMBO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .age_tick(age_tick), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_tag(rsp_tag), .rsp_index(rsp_index), .rsp_age(rsp_age),
    .occupancy(occupancy), .expired_cnt(expired_cnt)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [TW-1:0] tag;
    logic [2:0]    idx;
    logic [AW-1:0] age;
  } rsp_t;

  rsp_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            m_valid[D];
  logic [TW-1:0] m_tag[D];
  int            m_age[D];
  int            m_exp = 0;
  bit            ghost_next = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 1'b0;
      m_age[i]   = 0;
    end
    m_exp = 0;
  endfunction

  function automatic void model_tick(input logic t);
    if (t) begin
      for (int i = 0; i < D; i++) begin
        if (m_valid[i]) begin
          m_age[i] = (m_age[i] + 1 > MAXA) ? MAXA : m_age[i] + 1;
          if (m_age[i] == MAXA) begin
            m_valid[i] = 1'b0;
            if (m_exp < 65535) m_exp++;
          end
        end
      end
    end
  endfunction

  // Response is derived from pre-tick contents; retrieval happens before aging, a park after it.
  function automatic void model_search(input logic [1:0] op, input logic [TW-1:0] tag, input logic t);
    int   mi = -1;
    int   fi = -1;
    rsp_t e;
    for (int i = D - 1; i >= 0; i--) begin
      if (m_valid[i] && m_tag[i] == tag) mi = i;
      if (!m_valid[i]) fi = i;
    end
    e.st = 3'd0; e.tag = tag; e.idx = '0; e.age = '0;
    case (op)
      2'd0: begin
        if (mi >= 0) begin
          e.st = 3'd2; e.idx = 3'(mi); e.age = AW'(m_age[mi]);
        end else if (fi < 0) begin
          e.st = 3'd1;
        end else begin
          e.idx = 3'(fi);
        end
        model_tick(t);
        if (mi < 0 && fi >= 0) begin
          m_valid[fi] = 1'b1; m_tag[fi] = tag; m_age[fi] = 0;
        end
      end
      2'd1, 2'd2: begin
        if (mi >= 0) begin
          e.tag = m_tag[mi]; e.idx = 3'(mi); e.age = AW'(m_age[mi]);
          if (op == 2'd1) m_valid[mi] = 1'b0;
        end else if (ghost_next) begin
          e.st = 3'd4; e.age = AW'(MAXA); ghost_next = 1'b0;
        end else begin
          e.st = 3'd3;
        end
        model_tick(t);
      end
      default: begin
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      end
    endcase
    exp_q.push_back(e);
  endfunction

  task automatic check_state(input string nm);
    chk({nm, "_occupancy"}, 32'(occupancy), 32'(m_occ()));
    chk({nm, "_expired"}, 32'(expired_cnt), 32'(m_exp));
  endtask

  // All drivers start and end at 1 time unit after a rising edge.
  task automatic req(input logic [1:0] op, input logic [TW-1:0] tag, input logic t0, input logic t1, input int hold);
    rsp_t e;
    req_valid = 1'b1; req_op = op; req_tag = tag; age_tick = t0;
    @(posedge clk); model_tick(t0);
    #1 req_valid = 1'b0; age_tick = t1;
    chk("search_req_ready", 32'(req_ready), 32'd0);
    chk("search_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); model_search(op, tag, t1);
    #1 age_tick = 1'b0;
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    e = exp_q[$];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_outputs", 32'({rsp_status, rsp_tag, rsp_index, rsp_age}), 32'(e));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    check_state("post");
  endtask

  task automatic idle(input int n, input int tick_pct);
    for (int k = 0; k < n; k++) begin
      age_tick = ($urandom_range(0, 99) < tick_pct);
      @(posedge clk); model_tick(age_tick);
      #1 age_tick = 1'b0;
    end
    check_state("idle");
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rsp: actual status %0h tag %0h, required no response", rsp_status, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_status", 32'(rsp_status), 32'(e.st));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          chk("rsp_index", 32'(rsp_index), 32'(e.idx));
          chk("rsp_age", 32'(rsp_age), 32'(e.age));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] op;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_fields", 32'({rsp_status, rsp_tag, rsp_index, rsp_age}), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_expired", 32'(expired_cnt), 32'd0);

    req(2'd0, 16'hBEEF, 1'b0, 1'b0, 0);
    req(2'd0, 16'hBEEF, 1'b0, 1'b0, 0);
    req(2'd3, 16'h0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < D; i++) req(2'd0, 16'h1000 + 16'(i), 1'b0, 1'b0, 0);
    req(2'd0, 16'h1234, 1'b0, 1'b0, 0);
    chk("full_occupancy", 32'(occupancy), 32'd8);
    req(2'd1, 16'h1003, 1'b0, 1'b0, 0);
    req(2'd0, 16'h1234, 1'b0, 1'b0, 0);
    req(2'd3, 16'h0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 5; i++) req(2'd0, 16'h3000 + 16'(i), 1'b0, 1'b0, 0);
    req(2'd3, 16'h0000, 1'b0, 1'b0, 0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_expired", 32'(expired_cnt), 32'd0);

    req(2'd0, 16'h00A5, 1'b0, 1'b0, 0);
    idle(11, 100);
    req(2'd2, 16'h00A5, 1'b0, 1'b0, 0);
    idle(1, 100);
    chk("expire_count", 32'(expired_cnt), 32'd1);
    chk("expire_occupancy", 32'(occupancy), 32'd0);
`ifdef CAM_LIMBO_EN
    ghost_next = 1'b1;
`endif
    req(2'd1, 16'h00A5, 1'b0, 1'b0, 0);

    req(2'd0, 16'h0777, 1'b0, 1'b0, 0);
    idle(11, 100);
    req(2'd1, 16'h0777, 1'b0, 1'b1, 0);
    chk("race_expired", 32'(expired_cnt), 32'd1);

    req(2'd0, 16'h0101, 1'b0, 1'b0, 0);
    req(2'd2, 16'h0101, 1'b0, 1'b0, 5);

    req_valid = 1'b1; req_op = 2'd0; req_tag = 16'h5555;
    @(posedge clk); model_tick(1'b0);
    #1 req_valid = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_occupancy", 32'(occupancy), 32'd0);
    idle(3, 0);
    chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);

    req(2'd3, 16'h0000, 1'b0, 1'b0, 0);
    for (int n = 0; n < 200; n++) begin
      idle($urandom_range(0, 2), TICK_PCT);
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && $urandom_range(0, 3) != 0) op = 2'd0;
      req(op, 16'h2000 + 16'($urandom_range(0, 11)),
          1'($urandom_range(0, 99) < TICK_PCT), 1'($urandom_range(0, 99) < TICK_PCT),
          $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
